// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and sequencer for a single-port synchronous memory
// with registered read. Supports bounded lock ownership for read-modify-write sequences.
module mem_arbiter #(
    parameter int unsigned bits     = 32,
    parameter int unsigned width    = 32,
    parameter int unsigned max_lock = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             wen0,
    input  logic             lock0,
    input  logic [bits-1:0]  adr0,
    input  logic [width-1:0] din0,
    output logic             gnt0,
    output logic             rvalid0,
    output logic [width-1:0] dout0,
    input  logic             req1,
    input  logic             wen1,
    input  logic             lock1,
    input  logic [bits-1:0]  adr1,
    input  logic [width-1:0] din1,
    output logic             gnt1,
    output logic             rvalid1,
    output logic [width-1:0] dout1,
    output logic             mem_wen,
    output logic             mem_ren,
    output logic [bits-1:0]  mem_adr,
    output logic [width-1:0] mem_din,
    input  logic [width-1:0] mem_dout
);

    localparam int unsigned CW = $clog2(max_lock + 1);
    localparam logic [CW-1:0] MAXC = CW'(max_lock);

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } state_t;

    state_t        state_q, state_d;
    logic          prio_q, prio_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rvalid0_q, rvalid1_q;
    logic          g0, g1;
    logic          hold;
    logic          arb_prio;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            prio_q    <= 1'b0;
            cnt_q     <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            cnt_q     <= cnt_d;
            rvalid0_q <= gnt0 & ~wen0;
            rvalid1_q <= gnt1 & ~wen1;
        end
    end

    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        cnt_d    = cnt_q;
        g0       = 1'b0;
        g1       = 1'b0;
        hold     = 1'b0;
        arb_prio = prio_q;

        // Ownership is kept only while the owner holds lock and the budget is not
        // exhausted under contention; otherwise the other port gets first pick.
        case (state_q)
            OWN0: begin
                if (lock0 && !(cnt_q == MAXC && req1)) begin
                    hold = 1'b1;
                    g0   = req0;
                end else begin
                    arb_prio = 1'b1;
                end
            end
            OWN1: begin
                if (lock1 && !(cnt_q == MAXC && req0)) begin
                    hold = 1'b1;
                    g1   = req1;
                end else begin
                    arb_prio = 1'b0;
                end
            end
            default: ;
        endcase

        if (hold) begin
            if (cnt_q != MAXC) begin
                cnt_d = cnt_q + CW'(1);
            end
            if (g0) begin
                prio_d = 1'b1;
            end
            if (g1) begin
                prio_d = 1'b0;
            end
        end else begin
            if (req0 && req1) begin
                g0 = ~arb_prio;
                g1 = arb_prio;
            end else begin
                g0 = req0;
                g1 = req1;
            end
            state_d = IDLE;
            cnt_d   = '0;
            if (g0) begin
                prio_d = 1'b1;
                if (lock0) begin
                    state_d = OWN0;
                    cnt_d   = CW'(1);
                end
            end
            if (g1) begin
                prio_d = 1'b0;
                if (lock1) begin
                    state_d = OWN1;
                    cnt_d   = CW'(1);
                end
            end
        end
    end

    assign gnt0 = g0 & ~rst;
    assign gnt1 = g1 & ~rst;

    always_comb begin
        mem_wen = 1'b0;
        mem_ren = 1'b0;
        mem_adr = '0;
        mem_din = '0;
        if (gnt0) begin
            mem_wen = wen0;
            mem_ren = ~wen0;
            mem_adr = adr0;
            mem_din = din0;
        end else if (gnt1) begin
            mem_wen = wen1;
            mem_ren = ~wen1;
            mem_adr = adr1;
            mem_din = din1;
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign dout0   = mem_dout;
    assign dout1   = mem_dout;

endmodule
